// File: rtl/spi_pkg.sv
// Shared constants and types for the Manchester-coded SPI link (transmit and receive sides).
package spi_pkg;

  localparam int BITS_PER_BYTE = 8;
  localparam int FIFO_DEPTH    = 2;

  // Half-bit pairs as {first half, second half} on the data line.
  localparam logic [1:0] ONE_CODE  = 2'b10;
  localparam logic [1:0] ZERO_CODE = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND,
    DISCARD
  } state_t;

endpackage

// File: rtl/rx_byte_fifo.sv
// Small valid/ready output buffer for decoded bytes; drops and flags bytes that arrive when full.
module rx_byte_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = BITS_PER_BYTE,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             full, pop, write;

  assign valid_o    = (count_q != '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign pop        = valid_o && ready_i;
  // When full, a simultaneous pop frees the slot the new byte lands in.
  assign write      = push_i && (!full || pop);
  assign data_o     = mem_q[rd_ptr_q];
  assign overflow_o = overflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_i && full && !pop;
      if (write) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({write, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_manchester_rx.sv
// Manchester line decoder: registered input stage, half-bit FSM and LSB-first shift register
// feeding a small output buffer; code and framing faults surface as one-cycle pulses.
module spi_manchester_rx #(
  parameter int BITS_PER_BYTE = spi_pkg::BITS_PER_BYTE,
  parameter int FIFO_DEPTH    = spi_pkg::FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din,
  input  logic                     en_in,
  input  logic                     out_ready,
  output logic [BITS_PER_BYTE-1:0] out_data,
  output logic                     out_valid,
  output logic                     code_err,
  output logic                     frame_err,
  output logic                     overflow,
  output logic                     busy
);
  import spi_pkg::*;

  localparam int CNT_W = $clog2(BITS_PER_BYTE);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_BYTE - 1);

  state_t                   state_q;
  logic                     din_r_q, en_r_q, half_a_q;
  logic [CNT_W-1:0]         bit_cnt_q;
  logic [BITS_PER_BYTE-1:0] shreg_q, shreg_d;
  logic                     code_err_q, frame_err_q;
  logic [1:0]               code;
  logic                     bit_ok, push;

  always_comb begin
    code             = {half_a_q, din_r_q};
    bit_ok           = (code == ONE_CODE) || (code == ZERO_CODE);
    shreg_d          = shreg_q;
    shreg_d[bit_cnt_q] = (code == ONE_CODE);
    // The completing bit goes straight into the buffer so the byte is visible one edge later.
    push             = (state_q == SECOND) && en_r_q && bit_ok && (bit_cnt_q == LAST_BIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      din_r_q     <= 1'b0;
      en_r_q      <= 1'b0;
      half_a_q    <= 1'b0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      code_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      din_r_q     <= din;
      en_r_q      <= en_in;
      code_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          if (en_r_q) begin
            half_a_q <= din_r_q;
            state_q  <= SECOND;
          end
        end
        FIRST: begin
          if (!en_r_q) begin
            // Enable dropping on a byte boundary is the normal end of a frame.
            frame_err_q <= (bit_cnt_q != '0);
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            state_q     <= IDLE;
          end else begin
            half_a_q <= din_r_q;
            state_q  <= SECOND;
          end
        end
        SECOND: begin
          if (!en_r_q) begin
            frame_err_q <= 1'b1;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            state_q     <= IDLE;
          end else if (!bit_ok) begin
            code_err_q <= 1'b1;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            state_q    <= DISCARD;
          end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
            state_q   <= FIRST;
          end
        end
        DISCARD: begin
          if (!en_r_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign code_err  = code_err_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

  rx_byte_fifo #(
    .WIDTH(BITS_PER_BYTE),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(shreg_d),
    .ready_i    (out_ready),
    .data_o     (out_data),
    .valid_o    (out_valid),
    .overflow_o (overflow)
  );

endmodule
